// File: rtl/rv32i_types.sv
// Shared types for the issue queue: default widths, CDB broadcast, source operand and entry records.
package rv32i_types;

  localparam int IQ_DEPTH_DEF         = 8;
  localparam int IQ_XLEN_DEF          = 32;
  localparam int IQ_TAG_WIDTH_DEF     = 6;
  localparam int IQ_ROB_IDX_WIDTH_DEF = 5;
  localparam int IQ_PAYLOAD_WIDTH_DEF = 64;

  typedef struct packed {
    logic [IQ_TAG_WIDTH_DEF-1:0] tag;
    logic [IQ_XLEN_DEF-1:0]      data;
  } cdb_t;

  typedef struct packed {
    logic [IQ_TAG_WIDTH_DEF-1:0] tag;
    logic                        rdy;
    logic [IQ_XLEN_DEF-1:0]      data;
  } src_t;

  typedef struct packed {
    logic                            valid;
    logic [IQ_PAYLOAD_WIDTH_DEF-1:0] payload;
    logic [IQ_ROB_IDX_WIDTH_DEF-1:0] rob_idx;
    src_t                            rs1;
    src_t                            rs2;
  } iq_entry_t;

endpackage

// File: rtl/iq_age_matrix.sv
// Age matrix for oldest-first selection; older_q[i][j] set means entry i was allocated before entry j.
// Only instantiated when IQ_AGE_SELECT_EN is defined.
module iq_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic [DEPTH-1:0] eligible_i,
  output logic [DEPTH-1:0] grant_o
);

  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];
  logic [DEPTH-1:0] blocked;

  // A new entry is younger than everything; a freed entry stops blocking anyone.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      older_d[i] = older_q[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (alloc_i[j] && (i != j)) older_d[i][j] = 1'b1;
        if (free_i[j])              older_d[i][j] = 1'b0;
      end
      if (alloc_i[i]) older_d[i] = '0;
    end
  end

  always_comb begin
    blocked = '0;
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (eligible_i[j] && older_q[j][i]) blocked[i] = 1'b1;
      end
      grant_o[i] = eligible_i[i] && !blocked[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      older_q <= older_d;
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue: holds renamed ops, captures sources from the CDB, issues one ready op per cycle.
// Define IQ_AGE_SELECT_EN for oldest-first selection; otherwise the lowest-index ready entry issues.
module issue_queue
  import rv32i_types::*;
#(
  parameter int DEPTH         = IQ_DEPTH_DEF,
  parameter int XLEN          = IQ_XLEN_DEF,
  parameter int TAG_WIDTH     = IQ_TAG_WIDTH_DEF,
  parameter int ROB_IDX_WIDTH = IQ_ROB_IDX_WIDTH_DEF,
  parameter int PAYLOAD_WIDTH = IQ_PAYLOAD_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       dispatch_valid,
  output logic                       dispatch_ready,
  input  logic [PAYLOAD_WIDTH-1:0]   dispatch_payload,
  input  logic [ROB_IDX_WIDTH-1:0]   dispatch_rob_idx,
  input  logic [TAG_WIDTH-1:0]       dispatch_rs1_tag,
  input  logic                       dispatch_rs1_rdy,
  input  logic [XLEN-1:0]            dispatch_rs1_data,
  input  logic [TAG_WIDTH-1:0]       dispatch_rs2_tag,
  input  logic                       dispatch_rs2_rdy,
  input  logic [XLEN-1:0]            dispatch_rs2_data,
  input  logic                       cdb_valid,
  input  logic [TAG_WIDTH-1:0]       cdb_tag,
  input  logic [XLEN-1:0]            cdb_data,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [PAYLOAD_WIDTH-1:0]   issue_payload,
  output logic [ROB_IDX_WIDTH-1:0]   issue_rob_idx,
  output logic [XLEN-1:0]            issue_rs1_data,
  output logic [XLEN-1:0]            issue_rs2_data,
  output logic [$clog2(DEPTH+1)-1:0] free_count,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic                 rdy;
    logic [XLEN-1:0]      data;
  } source_t;

  typedef struct packed {
    logic                     valid;
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic [ROB_IDX_WIDTH-1:0] rob_idx;
    source_t                  rs1;
    source_t                  rs2;
  } entry_t;

  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];
  logic [DEPTH-1:0] eligible;
  logic [DEPTH-1:0] alloc_oh;
  logic [DEPTH-1:0] grant_oh;
  logic [CW-1:0]    valid_cnt;
  logic             alloc_found;
  logic             dispatch_fire;
  logic             issue_fire;
  logic             cdb_hit_en;
  source_t          new_rs1;
  source_t          new_rs2;

  // Tag 0 is x0 and always arrives ready, so a broadcast on it must never wake anything.
  function automatic source_t wake(input source_t s, input logic en,
                                   input logic [TAG_WIDTH-1:0] tag, input logic [XLEN-1:0] data);
    wake = s;
    if (en && !s.rdy && (s.tag == tag)) begin
      wake.rdy  = 1'b1;
      wake.data = data;
    end
  endfunction

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elig
    assign eligible[gi] = entry_q[gi].valid && entry_q[gi].rs1.rdy && entry_q[gi].rs2.rdy;
  end

  always_comb begin
    valid_cnt   = '0;
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_cnt = valid_cnt + CW'(entry_q[i].valid);
      if (!entry_q[i].valid && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  // Full is judged on registered occupancy, so a slot freed by this cycle's issue is not reused yet.
  assign free_count     = CW'(DEPTH) - valid_cnt;
  assign empty          = (valid_cnt == '0);
  assign dispatch_ready = (valid_cnt != CW'(DEPTH)) && !flush;
  assign dispatch_fire  = dispatch_valid && dispatch_ready;
  assign issue_valid    = (|eligible) && !flush;
  assign issue_fire     = issue_valid && issue_ready;
  assign cdb_hit_en     = cdb_valid && (cdb_tag != '0);

`ifdef IQ_AGE_SELECT_EN
  logic [DEPTH-1:0] alloc_fire_oh;
  logic [DEPTH-1:0] free_fire_oh;

  assign alloc_fire_oh = dispatch_fire ? alloc_oh : '0;
  assign free_fire_oh  = issue_fire ? grant_oh : '0;

  iq_age_matrix #(.DEPTH(DEPTH)) u_age_matrix (
    .clk        (clk),
    .rst        (rst),
    .alloc_i    (alloc_fire_oh),
    .free_i     (free_fire_oh),
    .eligible_i (eligible),
    .grant_o    (grant_oh)
  );
`else
  logic sel_found;

  always_comb begin
    grant_oh  = '0;
    sel_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible[i] && !sel_found) begin
        grant_oh[i] = 1'b1;
        sel_found   = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    issue_payload  = '0;
    issue_rob_idx  = '0;
    issue_rs1_data = '0;
    issue_rs2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant_oh[i]) begin
        issue_payload  = entry_q[i].payload;
        issue_rob_idx  = entry_q[i].rob_idx;
        issue_rs1_data = entry_q[i].rs1.data;
        issue_rs2_data = entry_q[i].rs2.data;
      end
    end
  end

  always_comb begin
    new_rs1.tag  = dispatch_rs1_tag;
    new_rs1.rdy  = dispatch_rs1_rdy;
    new_rs1.data = dispatch_rs1_data;
    new_rs2.tag  = dispatch_rs2_tag;
    new_rs2.rdy  = dispatch_rs2_rdy;
    new_rs2.data = dispatch_rs2_data;
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i]     = entry_q[i];
      entry_d[i].rs1 = wake(entry_q[i].rs1, cdb_hit_en, cdb_tag, cdb_data);
      entry_d[i].rs2 = wake(entry_q[i].rs2, cdb_hit_en, cdb_tag, cdb_data);
      if (issue_fire && grant_oh[i]) entry_d[i].valid = 1'b0;
      if (dispatch_fire && alloc_oh[i]) begin
        entry_d[i].valid   = 1'b1;
        entry_d[i].payload = dispatch_payload;
        entry_d[i].rob_idx = dispatch_rob_idx;
        entry_d[i].rs1     = wake(new_rs1, cdb_hit_en, cdb_tag, cdb_data);
        entry_d[i].rs2     = wake(new_rs2, cdb_hit_en, cdb_tag, cdb_data);
      end
      if (flush) entry_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: stimulus pushes expected issues, a negedge monitor pops and compares.
// Expected order in the age test follows IQ_AGE_SELECT_EN.
module tb_issue_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic [63:0] dispatch_payload;
  logic [4:0]  dispatch_rob_idx;
  logic [5:0]  dispatch_rs1_tag;
  logic        dispatch_rs1_rdy;
  logic [31:0] dispatch_rs1_data;
  logic [5:0]  dispatch_rs2_tag;
  logic        dispatch_rs2_rdy;
  logic [31:0] dispatch_rs2_data;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        issue_valid;
  logic        issue_ready;
  logic [63:0] issue_payload;
  logic [4:0]  issue_rob_idx;
  logic [31:0] issue_rs1_data;
  logic [31:0] issue_rs2_data;
  logic [3:0]  free_count;
  logic        empty;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] payload;
    logic [4:0]  rob;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } exp_t;

  exp_t sb[$];

  issue_queue dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .dispatch_valid    (dispatch_valid),
    .dispatch_ready    (dispatch_ready),
    .dispatch_payload  (dispatch_payload),
    .dispatch_rob_idx  (dispatch_rob_idx),
    .dispatch_rs1_tag  (dispatch_rs1_tag),
    .dispatch_rs1_rdy  (dispatch_rs1_rdy),
    .dispatch_rs1_data (dispatch_rs1_data),
    .dispatch_rs2_tag  (dispatch_rs2_tag),
    .dispatch_rs2_rdy  (dispatch_rs2_rdy),
    .dispatch_rs2_data (dispatch_rs2_data),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .cdb_data          (cdb_data),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_payload     (issue_payload),
    .issue_rob_idx     (issue_rob_idx),
    .issue_rs1_data    (issue_rs1_data),
    .issue_rs2_data    (issue_rs2_data),
    .free_count        (free_count),
    .empty             (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t e;
    e.payload = {32'hC0DE_0000, 32'(id)};
    e.rob     = 5'(id);
    e.rs1     = rs1;
    e.rs2     = rs2;
    return e;
  endfunction

  task automatic drive(input int id, input logic [5:0] t1, input logic r1, input logic [31:0] d1,
                       input logic [5:0] t2, input logic r2, input logic [31:0] d2);
    dispatch_valid    = 1'b1;
    dispatch_payload  = {32'hC0DE_0000, 32'(id)};
    dispatch_rob_idx  = 5'(id);
    dispatch_rs1_tag  = t1;
    dispatch_rs1_rdy  = r1;
    dispatch_rs1_data = d1;
    dispatch_rs2_tag  = t2;
    dispatch_rs2_rdy  = r2;
    dispatch_rs2_data = d2;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Monitor: every accepted issue must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && issue_valid && issue_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", {59'd0, issue_rob_idx}, 64'hFFFF);
      end else begin
        e = sb.pop_front();
        check("issue_payload", issue_payload, e.payload);
        check("issue_rob_idx", {59'd0, issue_rob_idx}, {59'd0, e.rob});
        check("issue_rs1_data", {32'd0, issue_rs1_data}, {32'd0, e.rs1});
        check("issue_rs2_data", {32'd0, issue_rs2_data}, {32'd0, e.rs2});
        $display("issue rob=%0d payload=0x%0h rs1=0x%0h rs2=0x%0h", issue_rob_idx, issue_payload,
                 issue_rs1_data, issue_rs2_data);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    issue_ready = 1'b0;
    dispatch_payload = '0; dispatch_rob_idx = '0;
    dispatch_rs1_tag = '0; dispatch_rs1_rdy = 1'b0; dispatch_rs1_data = '0;
    dispatch_rs2_tag = '0; dispatch_rs2_rdy = 1'b0; dispatch_rs2_data = '0;
    cdb_tag = '0; cdb_data = '0;
    idle();
    #2;
    check("rst_issue_valid", issue_valid, 0);
    check("rst_dispatch_ready", dispatch_ready, 1);
    check("rst_free_count", free_count, 8);
    check("rst_empty", empty, 1);
    check("rst_issue_rs1_data", issue_rs1_data, 0);
    tick();
    rst = 1'b0;

    // Both operands ready at dispatch.
    drive(1, 0, 1, 5, 0, 1, 7);
    issue_ready = 1'b1;
    sb.push_back(mk(1, 5, 7));
    settle();
    check("t1_issue_valid_dispatch_cycle", issue_valid, 0);
    check("t1_dispatch_ready", dispatch_ready, 1);
    tick(); idle(); settle();
    check("t1_issue_valid_next", issue_valid, 1);
    check("t1_free_count_held", free_count, 7);
    tick(); settle();
    check("t1_free_count_after", free_count, 8);
    check("t1_empty_after", empty, 1);

    // Wakeup two cycles after dispatch.
    drive(2, 12, 0, 0, 0, 1, 32'h11);
    sb.push_back(mk(2, 32'hDEAD, 32'h11));
    tick(); idle(); settle();
    check("t2_wait_issue_valid", issue_valid, 0);
    tick(); cdb(12, 32'hDEAD); settle();
    check("t2_broadcast_cycle_issue_valid", issue_valid, 0);
    tick(); idle(); settle();
    check("t2_issue_valid_after_wake", issue_valid, 1);
    tick();

    // Same-cycle dispatch and broadcast bypass.
    drive(3, 0, 1, 4, 9, 0, 0);
    cdb(9, 3);
    sb.push_back(mk(3, 4, 3));
    tick(); idle(); settle();
    check("t3_bypass_issue_valid", issue_valid, 1);
    tick();

    // Both sources wake on a single broadcast.
    drive(4, 15, 0, 0, 15, 0, 0);
    sb.push_back(mk(4, 32'h55, 32'h55));
    tick(); idle(); cdb(15, 32'h55);
    tick(); idle(); settle();
    check("t4_dual_wake_issue_valid", issue_valid, 1);
    tick();

    // Fill to capacity with the FU stalled.
    issue_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(10 + k, 0, 1, 32'(k), 0, 1, 32'(k + 100));
      tick();
    end
    idle(); settle();
    check("full_dispatch_ready", dispatch_ready, 0);
    check("full_free_count", free_count, 0);
    check("full_issue_valid", issue_valid, 1);
    sb.push_back(mk(10, 0, 100));
    issue_ready = 1'b1;
    drive(20, 0, 1, 20, 0, 1, 120);
    settle();
    check("full_no_same_cycle_reuse", dispatch_ready, 0);
    tick();
    issue_ready = 1'b0;
    settle();
    check("full_ready_after_free", dispatch_ready, 1);
    check("full_free_count_one", free_count, 1);
    tick(); idle(); settle();
    check("full_refilled", free_count, 0);
`ifdef IQ_AGE_SELECT_EN
    for (int k = 1; k < 8; k++) sb.push_back(mk(10 + k, 32'(k), 32'(k + 100)));
    sb.push_back(mk(20, 20, 120));
`else
    sb.push_back(mk(20, 20, 120));
    for (int k = 1; k < 8; k++) sb.push_back(mk(10 + k, 32'(k), 32'(k + 100)));
`endif
    issue_ready = 1'b1;
    repeat (8) tick();
    issue_ready = 1'b0;
    settle();
    check("drain_empty", empty, 1);

    // Age vs index order: A lands in entry 3, B later in entry 0.
    tick();
    drive(30, 0, 1, 30, 0, 1, 130); tick();
    drive(31, 21, 0, 0, 0, 1, 131); tick();
    drive(32, 22, 0, 0, 0, 1, 132); tick();
    drive(33, 0, 1, 33, 0, 1, 133); tick();
    idle();
    sb.push_back(mk(30, 30, 130));
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    drive(34, 0, 1, 34, 0, 1, 134);
    tick(); idle(); settle();
`ifdef IQ_AGE_SELECT_EN
    check("age_held_selection", issue_rob_idx, 5'(33));
    sb.push_back(mk(33, 33, 133));
    sb.push_back(mk(34, 34, 134));
`else
    check("age_held_selection", issue_rob_idx, 5'(34));
    sb.push_back(mk(34, 34, 134));
    sb.push_back(mk(33, 33, 133));
`endif
    issue_ready = 1'b1;
    tick(); tick();
    cdb(21, 32'h21);
    sb.push_back(mk(31, 32'h21, 131));
    tick();
    cdb(22, 32'h22);
    sb.push_back(mk(32, 32'h22, 132));
    tick(); idle();
    tick();
    issue_ready = 1'b0;
    settle();
    check("age_empty", empty, 1);

    // Flush with four valid entries while CDB and dispatch are active.
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(40 + k, 0, 1, 32'(k), 0, 1, 32'(k));
      tick();
    end
    idle();
    drive(44, 0, 1, 1, 0, 1, 1);
    cdb(5, 32'h77);
    flush = 1'b1;
    issue_ready = 1'b1;
    settle();
    check("flush_issue_valid", issue_valid, 0);
    check("flush_dispatch_ready", dispatch_ready, 0);
    tick(); idle(); issue_ready = 1'b0; settle();
    check("flush_empty", empty, 1);
    check("flush_free_count", free_count, 8);
    check("flush_issue_valid_after", issue_valid, 0);

    // Asynchronous reset between clock edges.
    tick();
    drive(50, 0, 1, 1, 0, 1, 2);
    tick(); idle(); settle();
    check("arst_pre_empty", empty, 0);
    rst = 1'b1;
    #1;
    check("arst_empty_immediate", empty, 1);
    check("arst_free_count_immediate", free_count, 8);
    tick();
    rst = 1'b0;
    settle();

    check("scoreboard_drained", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
